// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: reset image, alias slot
// address and helpers that move fields in and out of the flattened port buses.
package regfile_pkg;

    localparam int RF_MAX_W      = 64;
    localparam int RF_BUS_W      = 512;
    localparam int RF_ADDR_W_DEF = 4;
    localparam int RF_ALIAS_DEF  = (1 << RF_ADDR_W_DEF) - 1;

    function automatic int rf_alias_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    // r0 is zero, r1 is the sign-bit pattern, every other slot holds its own index
    function automatic logic [RF_MAX_W-1:0] rf_reset_val(input int idx, input int data_w);
        logic [RF_MAX_W-1:0] v;
        if (idx == 0) begin
            v = '0;
        end else if (idx == 1) begin
            v = RF_MAX_W'(1) << (data_w - 1);
        end else begin
            v = RF_MAX_W'(idx);
        end
        return v;
    endfunction

    function automatic logic [RF_MAX_W-1:0] rf_unpack(input logic [RF_BUS_W-1:0] bus,
                                                      input int k, input int w);
        logic [RF_BUS_W-1:0] mask;
        mask = (RF_BUS_W'(1) << w) - RF_BUS_W'(1);
        return RF_MAX_W'((bus >> (k * w)) & mask);
    endfunction

    function automatic logic [RF_BUS_W-1:0] rf_pack(input logic [RF_BUS_W-1:0] bus,
                                                    input int k, input int w,
                                                    input logic [RF_MAX_W-1:0] val);
        logic [RF_BUS_W-1:0] mask;
        mask = (RF_BUS_W'(1) << w) - RF_BUS_W'(1);
        return (bus & ~(mask << (k * w))) | ((RF_BUS_W'(val) & mask) << (k * w));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bus of the register file; the master drives strobes,
// addresses and data, the slave (the register file) returns read results.
interface regfile_mp_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int N_READ  = 3,
    parameter int N_WRITE = 2
);
    logic [DATA_W-1:0]         pc_i;
    logic [N_READ-1:0]         rd_en_i;
    logic [N_READ*ADDR_W-1:0]  rd_addr_i;
    logic [N_READ*DATA_W-1:0]  rd_data_o;
    logic [N_READ-1:0]         rd_pending_o;
    logic [N_WRITE-1:0]        wr_en_i;
    logic [N_WRITE*ADDR_W-1:0] wr_addr_i;
    logic [N_WRITE*DATA_W-1:0] wr_data_i;
    logic                      rsv_en_i;
    logic [ADDR_W-1:0]         rsv_addr_i;
    logic                      wr_conflict_o;

    modport master (
        output pc_i, rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        input  rd_data_o, rd_pending_o, wr_conflict_o
    );

    modport slave (
        input  pc_i, rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i,
        output rd_data_o, rd_pending_o, wr_conflict_o
    );

endinterface

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for one register address: reports whether any enabled port
// targets it, which port wins (highest index), and whether ports collided.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int N_WRITE = 2,
    parameter int SEL_W   = (N_WRITE > 1) ? $clog2(N_WRITE) : 1
) (
    input  logic [N_WRITE-1:0]        i_wr_en,
    input  logic [N_WRITE*ADDR_W-1:0] i_wr_addr,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic                      o_hit,
    output logic [SEL_W-1:0]          o_sel,
    output logic                      o_collide
);

    logic              w_hit;
    logic [SEL_W-1:0]  w_sel;
    logic              w_collide;
    logic [ADDR_W-1:0] w_port_addr;

    always_comb begin
        w_hit       = 1'b0;
        w_sel       = '0;
        w_collide   = 1'b0;
        w_port_addr = '0;
        // ascending scan so the last matching port overrides earlier ones
        for (int p = 0; p < N_WRITE; p++) begin
            w_port_addr = ADDR_W'(rf_unpack(RF_BUS_W'(i_wr_addr), p, ADDR_W));
            if (i_wr_en[p] && (w_port_addr == i_addr)) begin
                if (w_hit) begin
                    w_collide = 1'b1;
                end
                w_hit = 1'b1;
                w_sel = SEL_W'(p);
            end
        end
    end

    assign o_hit     = w_hit;
    assign o_sel     = w_sel;
    assign o_collide = w_collide;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, optional PC alias on the
// top slot and a pending-write scoreboard for in-flight loads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int N_READ   = 3,
    parameter int N_WRITE  = 2,
    parameter int PC_ALIAS = 1
) (
    input logic          clk_i,
    input logic          reset_ni,
    regfile_mp_if.slave  bus
);

    localparam int                N_REGS     = 1 << ADDR_W;
    localparam int                ALIAS_IDX  = rf_alias_addr(ADDR_W);
    localparam logic [ADDR_W-1:0] ALIAS_ADDR = ADDR_W'(ALIAS_IDX);
    localparam int                SEL_W      = (N_WRITE > 1) ? $clog2(N_WRITE) : 1;
    localparam int                RD_BUS_W   = N_READ * DATA_W;

    logic [DATA_W-1:0]   r_regs [N_REGS];
    logic [N_REGS-1:0]   r_pend;
    logic [DATA_W-1:0]   r_rd_data_p1 [N_READ];
    logic [N_READ-1:0]   r_rd_pend_p1;
    logic                r_wr_conflict_p1;

    logic [DATA_W-1:0]   w_wr_data [N_WRITE];
    logic [ADDR_W-1:0]   w_rd_addr [N_READ];
    logic [N_REGS-1:0]   w_sto_hit;
    logic [N_REGS-1:0]   w_sto_col;
    logic [N_REGS-1:0]   w_sto_we;
    logic [N_REGS-1:0]   w_pend_nxt;
    logic [SEL_W-1:0]    w_sto_sel [N_REGS];
    logic [DATA_W-1:0]   w_rd_data_nxt [N_READ];
    logic [N_READ-1:0]   w_rd_pend_nxt;
    logic [RF_BUS_W-1:0] w_rd_data_bus;

    always_comb begin
        for (int p = 0; p < N_WRITE; p++) begin
            w_wr_data[p] = DATA_W'(rf_unpack(RF_BUS_W'(bus.wr_data_i), p, DATA_W));
        end
        for (int k = 0; k < N_READ; k++) begin
            w_rd_addr[k] = ADDR_W'(rf_unpack(RF_BUS_W'(bus.rd_addr_i), k, ADDR_W));
        end
    end

    // One arbiter per address: drives the storage write, the read bypass (indexed
    // by read address) and collision detection, alias slot included.
    for (genvar a = 0; a < N_REGS; a++) begin : g_slot
        regfile_wr_arb #(
            .ADDR_W  (ADDR_W),
            .N_WRITE (N_WRITE),
            .SEL_W   (SEL_W)
        ) u_arb (
            .i_wr_en   (bus.wr_en_i),
            .i_wr_addr (bus.wr_addr_i),
            .i_addr    (ADDR_W'(a)),
            .o_hit     (w_sto_hit[a]),
            .o_sel     (w_sto_sel[a]),
            .o_collide (w_sto_col[a])
        );

        if ((PC_ALIAS != 0) && (a == ALIAS_IDX)) begin : g_alias
            assign w_sto_we[a]   = 1'b0;
            assign w_pend_nxt[a] = 1'b0;
        end else begin : g_stored
            // reserve beats a same-cycle write: the older writer clears, the new load sets
            assign w_sto_we[a]   = w_sto_hit[a];
            assign w_pend_nxt[a] = (bus.rsv_en_i && (bus.rsv_addr_i == ADDR_W'(a))) ? 1'b1 :
                                   w_sto_hit[a] ? 1'b0 : r_pend[a];
        end
    end

    always_comb begin
        for (int k = 0; k < N_READ; k++) begin
            w_rd_data_nxt[k] = r_regs[w_rd_addr[k]];
            w_rd_pend_nxt[k] = w_pend_nxt[w_rd_addr[k]];
            if ((PC_ALIAS != 0) && (w_rd_addr[k] == ALIAS_ADDR)) begin
                w_rd_data_nxt[k] = bus.pc_i;
                w_rd_pend_nxt[k] = 1'b0;
            end else if (w_sto_hit[w_rd_addr[k]]) begin
                w_rd_data_nxt[k] = w_wr_data[w_sto_sel[w_rd_addr[k]]];
            end
        end
    end

    // ---- stage p1: storage, scoreboard and registered read results ----
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int a = 0; a < N_REGS; a++) begin
                r_regs[a] <= DATA_W'(rf_reset_val(a, DATA_W));
            end
            for (int k = 0; k < N_READ; k++) begin
                r_rd_data_p1[k] <= '0;
            end
            r_pend           <= '0;
            r_rd_pend_p1     <= '0;
            r_wr_conflict_p1 <= 1'b0;
        end else begin
            for (int a = 0; a < N_REGS; a++) begin
                if (w_sto_we[a]) begin
                    r_regs[a] <= w_wr_data[w_sto_sel[a]];
                end
            end
            for (int k = 0; k < N_READ; k++) begin
                if (bus.rd_en_i[k]) begin
                    r_rd_data_p1[k] <= w_rd_data_nxt[k];
                    r_rd_pend_p1[k] <= w_rd_pend_nxt[k];
                end
            end
            r_pend           <= w_pend_nxt;
            r_wr_conflict_p1 <= |w_sto_col;
        end
    end

    always_comb begin
        w_rd_data_bus = '0;
        for (int k = 0; k < N_READ; k++) begin
            w_rd_data_bus = rf_pack(w_rd_data_bus, k, DATA_W, RF_MAX_W'(r_rd_data_p1[k]));
        end
    end

    assign bus.rd_data_o     = RD_BUS_W'(w_rd_data_bus);
    assign bus.rd_pending_o  = r_rd_pend_p1;
    assign bus.wr_conflict_o = r_wr_conflict_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected read/conflict results,
// a negedge monitor pops and compares them whenever the DUT presents a result.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;
    localparam int NW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          pend;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW)) bus ();

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .N_READ   (NR),
        .N_WRITE  (NW),
        .PC_ALIAS (1)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    rd_exp_t       rd_q [NR][$];
    logic          cf_q [$];
    rd_exp_t       mon_e;
    logic          mon_cf;
    int            checks = 0;
    int            errors = 0;
    logic          issue  = 1'b0;
    logic [NR-1:0] vld_p1 = '0;
    logic          chk_p1 = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Which ports returned a result at the last edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= '0;
            chk_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue ? bus.rd_en_i : '0;
            chk_p1 <= issue;
        end
    end

    always @(negedge clk) begin
        if (chk_p1) begin
            if (cf_q.size() == 0) begin
                check("cf_queue_underflow", 32'd1, 32'd0);
            end else begin
                mon_cf = cf_q.pop_front();
                check("wr_conflict", 32'(bus.wr_conflict_o), 32'(mon_cf));
            end
        end
        for (int k = 0; k < NR; k++) begin
            if (vld_p1[k]) begin
                if (rd_q[k].size() == 0) begin
                    check($sformatf("rd%0d_queue_underflow", k), 32'd1, 32'd0);
                end else begin
                    mon_e = rd_q[k].pop_front();
                    check($sformatf("rd%0d_data", k), bus.rd_data_o[k*DW +: DW], mon_e.data);
                    check($sformatf("rd%0d_pending", k), 32'(bus.rd_pending_o[k]), 32'(mon_e.pend));
                end
            end
        end
    end

    task automatic idle_bus();
        bus.rd_en_i  = '0;
        bus.wr_en_i  = '0;
        bus.rsv_en_i = 1'b0;
    endtask

    task automatic rd(input int k, input int a, input logic [DW-1:0] d, input int p);
        rd_exp_t e;
        bus.rd_en_i[k]              = 1'b1;
        bus.rd_addr_i[k*AW +: AW]   = AW'(a);
        e.data                      = d;
        e.pend                      = (p != 0);
        rd_q[k].push_back(e);
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        bus.wr_en_i[p]            = 1'b1;
        bus.wr_addr_i[p*AW +: AW] = AW'(a);
        bus.wr_data_i[p*DW +: DW] = d;
    endtask

    task automatic rsv(input int a);
        bus.rsv_en_i   = 1'b1;
        bus.rsv_addr_i = AW'(a);
    endtask

    task automatic step(input int exp_cf);
        cf_q.push_back(exp_cf != 0);
        issue = 1'b1;
        @(posedge clk);
        #1;
        issue = 1'b0;
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.pc_i       = '0;
        bus.rd_addr_i  = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.rsv_addr_i = '0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            check($sformatf("reset_rd%0d_data", k), bus.rd_data_o[k*DW +: DW], 32'h0);
        end
        check("reset_pending", 32'(bus.rd_pending_o), 32'h0);
        check("reset_conflict", 32'(bus.wr_conflict_o), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset image
        rd(0, 0, 32'h0000_0000, 0); rd(1, 1, 32'h8000_0000, 0); rd(2, 5, 32'h0000_0005, 0);
        step(0);

        // PC alias: writes to slot 15 dropped, reads follow pc_i
        bus.pc_i = 32'h0000_0100;
        rd(0, 15, 32'h0000_0100, 0); wr(0, 15, 32'h0000_DEAD);
        step(0);
        bus.pc_i = 32'h0000_0104;
        rd(0, 15, 32'h0000_0104, 0);
        step(0);

        // two ports hit r3: port 1 wins, bypassed, conflict flagged
        wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(1, 3, 32'h22, 0);
        step(1);
        rd(2, 3, 32'h22, 0);
        step(0);

        // collision on the alias slot still flags; reserving it does nothing
        wr(0, 15, 32'h1); wr(1, 15, 32'h2); rsv(15); rd(0, 15, 32'h0000_0104, 0);
        step(1);

        // scoreboard: reserve r4, then the load write clears it
        rsv(4); rd(0, 4, 32'h4, 1);
        step(0);
        rd(1, 4, 32'h4, 1);
        step(0);
        wr(0, 4, 32'h77); rd(1, 4, 32'h77, 0);
        step(0);
        rd(2, 4, 32'h77, 0);
        step(0);

        // reserve and write r6 in one cycle: reserve wins
        rsv(6); wr(1, 6, 32'h55); rd(2, 6, 32'h55, 1);
        step(0);
        rd(0, 6, 32'h55, 1); rd(1, 15, 32'h0000_0104, 0);
        step(0);

        // no read strobe: outputs hold
        step(0);
        check("hold_rd0_data", bus.rd_data_o[0 +: DW], 32'h55);
        check("hold_rd0_pending", 32'(bus.rd_pending_o[0]), 32'h1);

        // independent writes on both ports plus a plain stored read
        wr(0, 7, 32'hA); wr(1, 8, 32'hB); rd(0, 7, 32'hA, 0); rd(1, 8, 32'hB, 0); rd(2, 9, 32'h9, 0);
        step(0);

        // write r2 and reserve r10, then pulse reset mid-cycle
        wr(0, 2, 32'hAB); rsv(10);
        step(0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NR; k++) begin
            check($sformatf("async_rst_rd%0d_data", k), bus.rd_data_o[k*DW +: DW], 32'h0);
        end
        check("async_rst_pending", 32'(bus.rd_pending_o), 32'h0);
        check("async_rst_conflict", 32'(bus.wr_conflict_o), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(0, 2, 32'h2, 0); rd(1, 10, 32'hA, 0); rd(2, 6, 32'h6, 0);
        step(0);
        @(negedge clk);
        #1;

        check("rd_queue_drained", 32'(rd_q[0].size() + rd_q[1].size() + rd_q[2].size()), 32'h0);
        check("cf_queue_drained", 32'(cf_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
